// File: rtl/sum_accumulator_if.sv
// Stream interface of the sum accumulator: adder sums in, accumulated totals out.
interface sum_accumulator_if #(
    parameter int IN_W  = 10,
    parameter int ACC_W = 12,
    parameter int CNT_W = 2
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic [CNT_W-1:0] sample_cnt;

    // Producer of samples and consumer of totals.
    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, overflow, drop_cnt, sample_cnt
    );

    // The accumulator itself.
    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, overflow, drop_cnt, sample_cnt
    );
endinterface

// File: rtl/sum_accumulator.sv
// Sums each group of ACC_LEN valid input samples and queues the totals in a
// first-word-fall-through FIFO; totals arriving at a full FIFO are dropped
// and counted.
module sum_accumulator #(
    parameter int IN_W       = 10,
    parameter int ACC_LEN    = 4,
    parameter int ACC_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,   // active-high synchronous reset
    sum_accumulator_if.slave   bus
);
    localparam int CNT_W = $clog2(ACC_LEN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACC_LEN - 1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] sample_cnt_r;
    logic [ACC_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             overflow_r;
    logic [7:0]       drop_cnt_r;

    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum_next;
    logic             grp_done;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;

    // Drop counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Zero-extension of an input sample to accumulator width; the width rule
    // guarantees the group total never exceeds ACC_W bits.
    function automatic logic [ACC_W-1:0] widen(input logic [IN_W-1:0] v);
        return {{(ACC_W - IN_W){1'b0}}, v};
    endfunction

    assign in_ext     = widen(bus.in_data);
    assign sum_next   = acc + in_ext;
    assign grp_done   = bus.in_valid && (sample_cnt_r == LAST_IDX);
    assign fifo_full  = (occ == OCC_FULL);
    assign fifo_empty = (occ == '0);
    // A pop at full frees the slot the simultaneous push needs.
    assign pop        = !fifo_empty && bus.out_ready;
    assign push       = grp_done && (!fifo_full || pop);
    assign drop       = grp_done && fifo_full && !pop;

    // Group accumulation: gaps in in_valid simply hold the partial sum.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc          <= '0;
            sample_cnt_r <= '0;
        end else if (bus.in_valid) begin
            if (sample_cnt_r == LAST_IDX) begin
                acc          <= '0;
                sample_cnt_r <= '0;
            end else begin
                acc          <= sum_next;
                sample_cnt_r <= sample_cnt_r + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observable through occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sum_next;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Overflow bookkeeping for totals lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else if (drop) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= sat_inc8(drop_cnt_r);
        end
    end

    // Outputs come from registered state only; an empty FIFO presents zero.
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_empty ? '0 : mem[rd_ptr];
    assign bus.overflow   = overflow_r;
    assign bus.drop_cnt   = drop_cnt_r;
    assign bus.sample_cnt = sample_cnt_r;
endmodule
